// File: rtl/draw_pkg.sv
// Shared types and default parameters for the random draw controller.
package draw_pkg;

  localparam int unsigned DefN        = 4;
  localparam int unsigned DefDrawCnt  = 6;
  localparam int unsigned DefSpinCyc  = 3;
  localparam int unsigned DefMaxRetry = 15;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StSpin,
    StWaitRdy,
    StCheck,
    StDone
  } draw_state_e;

endpackage

// File: rtl/draw_used_map.sv
// Bitmap of numbers already drawn: synchronous clear, single-bit set, combinational test.
module draw_used_map #(
  parameter int unsigned N = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         set_i,
  input  logic [N-1:0] set_idx_i,
  input  logic [N-1:0] test_idx_i,
  output logic         hit_o
);

  localparam int unsigned Size = 2 ** N;

  logic [Size-1:0] map_q, map_d;

  // Clear has priority over set.
  always_comb begin
    map_d = map_q;
    if (clr_i) begin
      map_d = '0;
    end else if (set_i) begin
      map_d[set_idx_i] = 1'b1;
    end
  end

  // Map storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      map_q <= '0;
    end else begin
      map_q <= map_d;
    end
  end

  assign hit_o = map_q[test_idx_i];

endmodule

// File: rtl/rand_draw_ctrl.sv
// Draws DRAW_CNT distinct numbers below a latched bound from an external generator,
// rejecting out-of-range and repeated samples. Define DRAW_TIMEOUT_EN to end a draw
// with an error once MAX_RETRY consecutive samples have been rejected.
module rand_draw_ctrl
  import draw_pkg::*;
#(
  parameter int unsigned N         = DefN,
  parameter int unsigned DRAW_CNT  = DefDrawCnt,
  parameter int unsigned SPIN_CYC  = DefSpinCyc,
  parameter int unsigned MAX_RETRY = DefMaxRetry
) (
  input  logic                          i_Clk,
  input  logic                          i_Rst,
  input  logic                          i_fStart,
  input  logic                          i_fClr,
  input  logic [N-1:0]                  i_Max,
  input  logic                          i_fRdy,
  input  logic [N-1:0]                  i_Num,
  output logic                          o_fShuffle,
  output logic                          o_fStop,
  output logic [N-1:0]                  o_Max,
  output logic                          o_fValid,
  output logic [N-1:0]                  o_Num,
  output logic [$clog2(DRAW_CNT+1)-1:0] o_Cnt,
  output logic                          o_fBusy,
  output logic                          o_fDone,
  output logic                          o_fErr
);

  localparam int unsigned CntW   = $clog2(DRAW_CNT + 1);
  localparam int unsigned SpinW  = (SPIN_CYC > 1) ? $clog2(SPIN_CYC) : 1;
  localparam int unsigned RetryW = $clog2(MAX_RETRY + 1);

  localparam logic [SpinW-1:0]  SpinLast = SpinW'(SPIN_CYC - 1);
  localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);
  localparam logic [CntW-1:0]   CntFull  = CntW'(DRAW_CNT);

  draw_state_e       state_q, state_d;
  logic [N-1:0]      max_q, max_d;
  logic [N-1:0]      num_q, num_d;
  logic [N-1:0]      sample_q, sample_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [SpinW-1:0]  spin_q, spin_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic              shuffle_q, shuffle_d;
  logic              stop_q, stop_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic map_clr, map_set, map_hit;

  draw_used_map #(
    .N(N)
  ) u_used_map (
    .clk_i      (i_Clk),
    .rst_ni     (i_Rst),
    .clr_i      (map_clr),
    .set_i      (map_set),
    .set_idx_i  (sample_q),
    .test_idx_i (sample_q),
    .hit_o      (map_hit)
  );

  // Next-state and next-output computation; outputs are derived from the next state
  // so every output is registered and aligned with the state it belongs to.
  always_comb begin
    state_d  = state_q;
    max_d    = max_q;
    num_d    = num_q;
    sample_d = sample_q;
    cnt_d    = cnt_q;
    spin_d   = spin_q;
    retry_d  = retry_q;
    err_d    = err_q;
    valid_d  = 1'b0;
    map_clr  = 1'b0;
    map_set  = 1'b0;

    if (i_fClr) begin
      state_d = StIdle;
      cnt_d   = '0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (i_fStart) begin
            max_d   = i_Max;
            map_clr = 1'b1;
            cnt_d   = '0;
            retry_d = '0;
            err_d   = 1'b0;
            // A range narrower than the draw can never complete.
            if (32'(i_Max) < DRAW_CNT) begin
              state_d = StDone;
              err_d   = 1'b1;
            end else begin
              state_d = StReq;
            end
          end
        end
        StReq: begin
          state_d = StSpin;
          spin_d  = '0;
        end
        StSpin: begin
          if (spin_q == SpinLast) begin
            state_d = StWaitRdy;
          end else begin
            spin_d = spin_q + SpinW'(1);
          end
        end
        StWaitRdy: begin
          if (i_fRdy) begin
            sample_d = i_Num;
            state_d  = StCheck;
          end
        end
        StCheck: begin
          if ((sample_q >= max_q) || map_hit) begin
            // Saturate so an unbounded retry run cannot wrap.
            if (retry_q != RetryMax) begin
              retry_d = retry_q + RetryW'(1);
            end
`ifdef DRAW_TIMEOUT_EN
            if (retry_d == RetryMax) begin
              state_d = StDone;
              err_d   = 1'b1;
            end else begin
              state_d = StReq;
            end
`else
            state_d = StReq;
`endif
          end else begin
            map_set = 1'b1;
            num_d   = sample_q;
            cnt_d   = cnt_q + CntW'(1);
            valid_d = 1'b1;
            retry_d = '0;
            state_d = (cnt_d == CntFull) ? StDone : StReq;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    shuffle_d = (state_d == StReq);
    stop_d    = (state_d == StSpin) && (spin_d == SpinLast);
    busy_d    = (state_d == StReq) || (state_d == StSpin) ||
                (state_d == StWaitRdy) || (state_d == StCheck);
    done_d    = (state_d == StDone);
  end

  // Controller state and registered outputs.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q   <= StIdle;
      max_q     <= '0;
      num_q     <= '0;
      sample_q  <= '0;
      cnt_q     <= '0;
      spin_q    <= '0;
      retry_q   <= '0;
      shuffle_q <= 1'b0;
      stop_q    <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      max_q     <= max_d;
      num_q     <= num_d;
      sample_q  <= sample_d;
      cnt_q     <= cnt_d;
      spin_q    <= spin_d;
      retry_q   <= retry_d;
      shuffle_q <= shuffle_d;
      stop_q    <= stop_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign o_fShuffle = shuffle_q;
  assign o_fStop    = stop_q;
  assign o_Max      = max_q;
  assign o_fValid   = valid_q;
  assign o_Num      = num_q;
  assign o_Cnt      = cnt_q;
  assign o_fBusy    = busy_q;
  assign o_fDone    = done_q;
  assign o_fErr     = err_q;

endmodule

// File: tb/tb_rand_draw_ctrl.sv
// Directed bench for rand_draw_ctrl with N=4, DRAW_CNT=3, SPIN_CYC=2, MAX_RETRY=4.
module tb_rand_draw_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, clr, rdy;
  logic [3:0] max_in, num_in;
  logic       shuffle, stop, valid, busy, done, err;
  logic [3:0] max_out, num_out;
  logic [1:0] cnt;

  int n_vec = 0;
  int n_err = 0;

  int sh_cnt = 0;
  int st_cnt = 0;
  int both_cnt = 0;
  int val_cnt = 0;
  logic [3:0] vals [64];

  rand_draw_ctrl #(
    .N         (4),
    .DRAW_CNT  (3),
    .SPIN_CYC  (2),
    .MAX_RETRY (4)
  ) dut (
    .i_Clk      (clk),
    .i_Rst      (rst_n),
    .i_fStart   (start),
    .i_fClr     (clr),
    .i_Max      (max_in),
    .i_fRdy     (rdy),
    .i_Num      (num_in),
    .o_fShuffle (shuffle),
    .o_fStop    (stop),
    .o_Max      (max_out),
    .o_fValid   (valid),
    .o_Num      (num_out),
    .o_Cnt      (cnt),
    .o_fBusy    (busy),
    .o_fDone    (done),
    .o_fErr     (err)
  );

  always #5 clk = ~clk;

  // Observe pulses away from the active edge.
  always @(negedge clk) begin
    if (shuffle) sh_cnt++;
    if (stop) st_cnt++;
    if (shuffle && stop) both_cnt++;
    if (valid) begin
      if (val_cnt < 64) vals[val_cnt] = num_out;
      val_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_start(input logic [3:0] m);
    @(negedge clk);
    start  = 1'b1;
    max_in = m;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Generator model: after each stop request, present one number for one cycle.
  task automatic serve(input logic [3:0] num);
    int w;
    w = 0;
    while (!stop && w < 50) begin
      @(negedge clk);
      w++;
    end
    n_vec++;
    if (!stop) begin
      n_err++;
      $display("FAIL serve_stop: o_fStop got 0 within 50 cycles, need 1");
    end else begin
      @(negedge clk);
      rdy    = 1'b1;
      num_in = num;
      @(negedge clk);
      rdy = 1'b0;
    end
  endtask

  task automatic wait_stop_then_one();
    int w;
    w = 0;
    while (!stop && w < 50) begin
      @(negedge clk);
      w++;
    end
    n_vec++;
    if (!stop) begin
      n_err++;
      $display("FAIL wait_stop: o_fStop got 0 within 50 cycles, need 1");
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_vec++;
    if ({shuffle, stop, valid, busy, done, err, cnt, max_out, num_out} !== 16'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h need 0",
               {shuffle, stop, valid, busy, done, err, cnt, max_out, num_out});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (sh_cnt !== 0 || st_cnt !== 0) begin
      n_err++;
      $display("FAIL reset_no_pulse: shuffles %0d stops %0d need 0 0", sh_cnt, st_cnt);
    end
  endtask

  task automatic test_basic();
    int sh0, v0;
    sh0 = sh_cnt;
    v0  = val_cnt;
    do_start(4'd6);
    n_vec++;
    if (busy !== 1'b1 || max_out !== 4'd6) begin
      n_err++;
      $display("FAIL basic_busy: busy %b max %0d need 1 6", busy, max_out);
    end
    serve(4'd2);
    serve(4'd5);
    serve(4'd1);
    repeat (2) @(negedge clk);
    n_vec++;
    if (val_cnt - v0 !== 3) begin
      n_err++;
      $display("FAIL basic_valid_cnt: got %0d need 3", val_cnt - v0);
    end
    n_vec++;
    if (vals[v0] !== 4'd2 || vals[v0+1] !== 4'd5 || vals[v0+2] !== 4'd1) begin
      n_err++;
      $display("FAIL basic_nums: got %0d %0d %0d need 2 5 1", vals[v0], vals[v0+1], vals[v0+2]);
    end
    n_vec++;
    if ({cnt, done, err, busy} !== {2'd3, 1'b1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL basic_end: cnt %0d done %b err %b busy %b need 3 1 0 0",
               cnt, done, err, busy);
    end
    n_vec++;
    if (sh_cnt - sh0 !== 3) begin
      n_err++;
      $display("FAIL basic_shuffles: got %0d need 3", sh_cnt - sh0);
    end
  endtask

  task automatic test_reject();
    int sh0, v0;
    sh0 = sh_cnt;
    v0  = val_cnt;
    do_start(4'd6);
    serve(4'd2);
    serve(4'd2);
    serve(4'd7);
    serve(4'd4);
    serve(4'd0);
    repeat (2) @(negedge clk);
    n_vec++;
    if (val_cnt - v0 !== 3) begin
      n_err++;
      $display("FAIL reject_valid_cnt: got %0d need 3", val_cnt - v0);
    end
    n_vec++;
    if (vals[v0] !== 4'd2 || vals[v0+1] !== 4'd4 || vals[v0+2] !== 4'd0) begin
      n_err++;
      $display("FAIL reject_nums: got %0d %0d %0d need 2 4 0", vals[v0], vals[v0+1], vals[v0+2]);
    end
    n_vec++;
    if (sh_cnt - sh0 !== 5) begin
      n_err++;
      $display("FAIL reject_shuffles: got %0d need 5", sh_cnt - sh0);
    end
    n_vec++;
    if ({cnt, done, err} !== {2'd3, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL reject_end: cnt %0d done %b err %b need 3 1 0", cnt, done, err);
    end
  endtask

  // Restart straight from DONE reusing the previous draw's numbers; also a start
  // while busy (with a too-small bound) must be ignored.
  task automatic test_back_to_back();
    int v0;
    v0 = val_cnt;
    do_start(4'd6);
    serve(4'd0);
    start  = 1'b1;
    max_in = 4'd2;
    @(negedge clk);
    start  = 1'b0;
    max_in = 4'd6;
    n_vec++;
    if (busy !== 1'b1 || err !== 1'b0 || max_out !== 4'd6) begin
      n_err++;
      $display("FAIL b2b_ignore_start: busy %b err %b max %0d need 1 0 6", busy, err, max_out);
    end
    serve(4'd2);
    serve(4'd4);
    repeat (2) @(negedge clk);
    n_vec++;
    if ({cnt, done, err} !== {2'd3, 1'b1, 1'b0} || val_cnt - v0 !== 3) begin
      n_err++;
      $display("FAIL b2b_end: cnt %0d done %b err %b valids %0d need 3 1 0 3",
               cnt, done, err, val_cnt - v0);
    end
  endtask

  task automatic test_small_max();
    int sh0;
    sh0 = sh_cnt;
    do_start(4'd2);
    n_vec++;
    if ({done, err, busy, cnt} !== {1'b1, 1'b1, 1'b0, 2'd0}) begin
      n_err++;
      $display("FAIL small_max_end: done %b err %b busy %b cnt %0d need 1 1 0 0",
               done, err, busy, cnt);
    end
    repeat (5) @(negedge clk);
    n_vec++;
    if (sh_cnt - sh0 !== 0) begin
      n_err++;
      $display("FAIL small_max_shuffle: got %0d need 0", sh_cnt - sh0);
    end
  endtask

  task automatic test_timeout();
    do_start(4'd6);
    serve(4'd3);
    for (int i = 0; i < 4; i++) serve(4'd3);
    repeat (2) @(negedge clk);
`ifdef DRAW_TIMEOUT_EN
    n_vec++;
    if ({err, done, busy, cnt} !== {1'b1, 1'b1, 1'b0, 2'd1}) begin
      n_err++;
      $display("FAIL timeout_end: err %b done %b busy %b cnt %0d need 1 1 0 1",
               err, done, busy, cnt);
    end
`else
    n_vec++;
    if ({busy, err, done, cnt} !== {1'b1, 1'b0, 1'b0, 2'd1}) begin
      n_err++;
      $display("FAIL timeout_busy: busy %b err %b done %b cnt %0d need 1 0 0 1",
               busy, err, done, cnt);
    end
`endif
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n_vec++;
    if ({busy, done, err, cnt} !== 5'b0) begin
      n_err++;
      $display("FAIL timeout_clr: busy %b done %b err %b cnt %0d need 0 0 0 0",
               busy, done, err, cnt);
    end
  endtask

  task automatic test_clear();
    int sh0, st0;
    do_start(4'd6);
    serve(4'd1);
    wait_stop_then_one();
    n_vec++;
    if (busy !== 1'b1 || cnt !== 2'd1) begin
      n_err++;
      $display("FAIL clr_pre: busy %b cnt %0d need 1 1", busy, cnt);
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n_vec++;
    if ({busy, done, err, valid, shuffle, stop, cnt} !== 8'b0) begin
      n_err++;
      $display("FAIL clr_wait_rdy: got %b need 00000000",
               {busy, done, err, valid, shuffle, stop, cnt});
    end
    sh0 = sh_cnt;
    st0 = st_cnt;
    repeat (8) @(negedge clk);
    n_vec++;
    if (sh_cnt - sh0 !== 0 || st_cnt - st0 !== 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL clr_idle: shuffles %0d stops %0d busy %b need 0 0 0",
               sh_cnt - sh0, st_cnt - st0, busy);
    end
    // Start and clear together: clear wins.
    start  = 1'b1;
    clr    = 1'b1;
    max_in = 4'd6;
    @(negedge clk);
    start = 1'b0;
    clr   = 1'b0;
    sh0   = sh_cnt;
    repeat (5) @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || sh_cnt - sh0 !== 0) begin
      n_err++;
      $display("FAIL start_clr: busy %b done %b shuffles %0d need 0 0 0",
               busy, done, sh_cnt - sh0);
    end
  endtask

  task automatic test_reset_mid_draw();
    int sh0, st0;
    do_start(4'd6);
    serve(4'd5);
    wait_stop_then_one();
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({shuffle, stop, valid, busy, done, err, cnt, max_out, num_out} !== 16'h0) begin
      n_err++;
      $display("FAIL reset_mid_draw: got %h need 0",
               {shuffle, stop, valid, busy, done, err, cnt, max_out, num_out});
    end
    @(negedge clk);
    rst_n = 1'b1;
    sh0   = sh_cnt;
    st0   = st_cnt;
    repeat (10) @(negedge clk);
    n_vec++;
    if (sh_cnt - sh0 !== 0 || st_cnt - st0 !== 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: shuffles %0d stops %0d busy %b need 0 0 0",
               sh_cnt - sh0, st_cnt - st0, busy);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    clr    = 1'b0;
    rdy    = 1'b0;
    max_in = 4'd0;
    num_in = 4'd0;

    test_reset();
    test_basic();
    test_reject();
    test_back_to_back();
    test_small_max();
    test_timeout();
    test_clear();
    test_reset_mid_draw();

    n_vec++;
    if (both_cnt !== 0) begin
      n_err++;
      $display("FAIL shuffle_stop_overlap: got %0d cycles need 0", both_cnt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
